// File: rtl/vga_pkg.sv
// Shared constants, FSM state type and burst sizing helper for the VGA line fetcher.
package vga_pkg;

  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int unsigned PAGE_BYTES    = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fetch_cs_t;

  // Beats for the next burst: bounded by the 4 KB page edge, the beats left and max_beats.
  function automatic logic [8:0] burst_len(input logic [11:0]   addr_lo,
                                           input logic [9:0]    remaining,
                                           input int unsigned   max_beats);
    logic [12:0] page_bytes;
    logic [9:0]  len;
    page_bytes = 13'(PAGE_BYTES) - {1'b0, addr_lo};
    len        = {1'b0, page_bytes[12:4]};
    if (remaining < len) len = remaining;
    if (10'(max_beats) < len) len = 10'(max_beats);
    return len[8:0];
  endfunction

endpackage

// File: rtl/vga_line_fetch.sv
// Memory-clock AXI4 read-address generator and beat tracker feeding the pixel FIFO.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W    = 27,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned MAX_BURST = 256,
  parameter int unsigned AXI_ID    = 0
) (
  input  logic              mem_clk,
  input  logic              mem_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [9:0]        req_words,
  output logic [3:0]        mem_arid,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic [7:0]        mem_arlen,
  output logic [2:0]        mem_arsize,
  output logic [1:0]        mem_arburst,
  output logic              mem_arlock,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rlast,
  output logic              mem_rready,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  input  logic              fifo_full,
  output logic              line_done,
  output logic              line_err
);

  fetch_cs_t         state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [9:0]        remaining;
  logic [9:0]        expected;
  logic [9:0]        beats_rcvd;
  logic [9:0]        beats_nxt;
  logic [8:0]        ar_beats;
  logic [ADDR_W-1:0] ar_step;
  logic              ar_fire;
  logic              count_en;
  logic              unused_ok;

  assign mem_arid    = 4'(AXI_ID);
  assign mem_arsize  = AXI_SIZE_16B;
  assign mem_arburst = AXI_BURST_INCR;
  assign mem_arlock  = 1'b0;

  assign req_ready  = (state == IDLE);
  assign mem_rready = ~fifo_full;
  assign fifo_wr_en = mem_rvalid & mem_rready;
  assign fifo_din   = mem_rdata;

  // Address advance reuses the registered arlen so it always matches the burst just accepted.
  assign ar_fire   = mem_arvalid & mem_arready;
  assign ar_beats  = {1'b0, mem_arlen} + 9'd1;
  assign ar_step   = ADDR_W'({ar_beats, 4'b0000});
  assign count_en  = (state != IDLE) && fifo_wr_en;
  assign beats_nxt = beats_rcvd + {9'd0, count_en};

  assign unused_ok = ^{mem_rlast, req_addr[3:0]};

  always_ff @(posedge mem_clk or negedge mem_reset) begin
    if (!mem_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid && (req_words != '0)) state_nxt = ISSUE;
      ISSUE:   if (ar_fire && (remaining == {1'b0, ar_beats})) state_nxt = DRAIN;
      DRAIN:   if (beats_nxt == expected) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge mem_reset) begin
    if (!mem_reset) begin
      cur_addr    <= '0;
      remaining   <= '0;
      expected    <= '0;
      beats_rcvd  <= '0;
      mem_araddr  <= '0;
      mem_arlen   <= '0;
      mem_arvalid <= 1'b0;
      line_done   <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      line_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur_addr   <= {req_addr[ADDR_W-1:4], 4'b0000};
            remaining  <= req_words;
            expected   <= req_words;
            beats_rcvd <= '0;
            line_err   <= 1'b0;
            line_done  <= (req_words == '0);
          end
        end
        ISSUE: begin
          // arvalid low marks a fresh burst to size; it stays low one cycle after each handshake.
          if (!mem_arvalid) begin
            mem_araddr  <= cur_addr;
            mem_arlen   <= 8'(burst_len(cur_addr[11:0], remaining, MAX_BURST) - 9'd1);
            mem_arvalid <= 1'b1;
          end else if (mem_arready) begin
            mem_arvalid <= 1'b0;
            cur_addr    <= cur_addr + ar_step;
            remaining   <= remaining - {1'b0, ar_beats};
          end
        end
        DRAIN: begin
          if (beats_nxt == expected) line_done <= 1'b1;
        end
        default: ;
      endcase
      if (count_en) begin
        beats_rcvd <= beats_nxt;
        if (mem_rresp != 2'b00) line_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed self-checking bench for vga_line_fetch.
module tb_vga_line_fetch;

  localparam int unsigned ADDR_W = 27;
  localparam int unsigned DATA_W = 128;

  logic              mem_clk;
  logic              mem_reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [9:0]        req_words;
  logic [3:0]        mem_arid;
  logic [ADDR_W-1:0] mem_araddr;
  logic [7:0]        mem_arlen;
  logic [2:0]        mem_arsize;
  logic [1:0]        mem_arburst;
  logic              mem_arlock;
  logic              mem_arvalid;
  logic              mem_arready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        mem_rresp;
  logic              mem_rlast;
  logic              mem_rready;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_din;
  logic              fifo_full;
  logic              line_done;
  logic              line_err;

  int checks   = 0;
  int failures = 0;

  vga_line_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(256), .AXI_ID(0)
  ) dut (
    .mem_clk(mem_clk), .mem_reset(mem_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_words(req_words),
    .mem_arid(mem_arid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen), .mem_arsize(mem_arsize),
    .mem_arburst(mem_arburst), .mem_arlock(mem_arlock), .mem_arvalid(mem_arvalid),
    .mem_arready(mem_arready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rresp(mem_rresp), .mem_rlast(mem_rlast), .mem_rready(mem_rready),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .line_done(line_done), .line_err(line_err)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] pattern(input int i);
    return {4{32'hA5A5_0000 + 32'(i)}};
  endfunction

  task automatic do_req(input logic [ADDR_W-1:0] addr, input logic [9:0] words);
    req_valid = 1'b1;
    req_addr  = addr;
    req_words = words;
    #1;
    check("req_ready_idle", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    check("arvalid_on_entry", mem_arvalid, 1'b0);
  endtask

  // Waits (bounded) for arvalid, holds arready low for stall cycles, then handshakes.
  task automatic do_ar(input logic [ADDR_W-1:0] addr, input logic [7:0] len, input int stall);
    int n = 0;
    while (!mem_arvalid && n < 20) begin
      tick();
      n++;
    end
    check("ar_valid", mem_arvalid, 1'b1);
    check("ar_addr", mem_araddr, addr);
    check("ar_len", mem_arlen, len);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("ar_stall_stable", {mem_arvalid, mem_araddr, mem_arlen}, {1'b1, addr, len});
    end
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    check("ar_drop_after_hs", mem_arvalid, 1'b0);
  endtask

  task automatic send_beats(input int n, input int err_idx, input int full_at);
    for (int i = 0; i < n; i++) begin
      if (i == full_at) begin
        for (int s = 0; s < 3; s++) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pattern(i);
          fifo_full  = 1'b1;
          #1;
          check("bp_rready", mem_rready, 1'b0);
          check("bp_wr_en", fifo_wr_en, 1'b0);
          tick();
          check("bp_no_done", line_done, 1'b0);
        end
      end
      fifo_full  = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = pattern(i);
      mem_rresp  = (i == err_idx) ? 2'd2 : 2'd0;
      mem_rlast  = (i == n - 1);
      #1;
      check("beat_wr_en", fifo_wr_en, 1'b1);
      check("beat_din", fifo_din, pattern(i));
      tick();
      if (i < n - 1) check("no_early_done", line_done, 1'b0);
      check("line_err_track", line_err, (err_idx >= 0 && i >= err_idx));
    end
    mem_rvalid = 1'b0;
    mem_rresp  = 2'd0;
    mem_rlast  = 1'b0;
  endtask

  task automatic finish_line(input logic err);
    check("line_done_pulse", line_done, 1'b1);
    check("line_err_at_done", line_err, err);
    check("no_ar_in_drain", mem_arvalid, 1'b0);
    tick();
    check("line_done_one_cycle", line_done, 1'b0);
    check("back_to_idle", req_ready, 1'b1);
  endtask

  initial begin
    mem_reset   = 1'b0;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_words   = '0;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    mem_rresp   = 2'd0;
    mem_rlast   = 1'b0;
    fifo_full   = 1'b0;

    tick();
    tick();
    check("rst_arvalid", mem_arvalid, 1'b0);
    check("rst_araddr", mem_araddr, 27'h0);
    check("rst_arlen", mem_arlen, 8'h0);
    check("rst_line_done", line_done, 1'b0);
    check("rst_line_err", line_err, 1'b0);
    check("rst_consts", {mem_arid, mem_arsize, mem_arburst, mem_arlock}, {4'h0, 3'b100, 2'b01, 1'b0});
    @(negedge mem_clk);
    mem_reset = 1'b1;
    tick();
    check("idle_req_ready", req_ready, 1'b1);

    // Single burst inside one page
    do_req(27'h100, 10'd40);
    do_ar(27'h100, 8'd39, 0);
    send_beats(40, -1, -1);
    finish_line(1'b0);

    // Page crossing splits into 8 + 32 beats
    do_req(27'hF80, 10'd40);
    do_ar(27'hF80, 8'd7, 0);
    do_ar(27'h1000, 8'd31, 0);
    send_beats(40, -1, -1);
    finish_line(1'b0);

    // Maximum line: two full 256-beat bursts
    do_req(27'h0, 10'd512);
    do_ar(27'h0, 8'd255, 0);
    do_ar(27'h1000, 8'd255, 0);
    send_beats(512, -1, -1);
    finish_line(1'b0);

    // arready stall and FIFO backpressure
    do_req(27'h2000, 10'd16);
    do_ar(27'h2000, 8'd15, 5);
    send_beats(16, -1, 5);
    finish_line(1'b0);

    // Error response on beat 7, low address bits ignored
    do_req(27'h300F, 10'd10);
    do_ar(27'h3000, 8'd9, 0);
    send_beats(10, 7, -1);
    finish_line(1'b1);
    check("line_err_sticky", line_err, 1'b1);

    // Zero-length line clears the error and completes with no AR
    req_valid = 1'b1;
    req_addr  = 27'h40;
    req_words = 10'd0;
    tick();
    req_valid = 1'b0;
    check("zero_done", line_done, 1'b1);
    check("zero_err_clear", line_err, 1'b0);
    check("zero_stay_idle", req_ready, 1'b1);
    check("zero_no_ar", mem_arvalid, 1'b0);
    tick();
    check("zero_done_pulse", line_done, 1'b0);
    check("zero_no_ar_after", mem_arvalid, 1'b0);

    // Reset mid-line abandons the burst immediately
    do_req(27'h5000, 10'd8);
    tick();
    check("mid_arvalid_up", mem_arvalid, 1'b1);
    #2;
    mem_reset = 1'b0;
    #1;
    check("mid_rst_arvalid", mem_arvalid, 1'b0);
    check("mid_rst_araddr", mem_araddr, 27'h0);
    check("mid_rst_idle", req_ready, 1'b1);
    @(negedge mem_clk);
    mem_reset = 1'b1;
    tick();
    tick();
    check("post_rst_no_ar", mem_arvalid, 1'b0);
    check("post_rst_no_done", line_done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch.md
Name: vga_line_fetch

Overview:
- Memory-clock AXI4 read-address generator and beat tracker for the VGA scan-out path.
- Accepts one line request (start byte address, 16-byte beat count) per scanline.
- Splits the request into INCR bursts that never cross a 4 KB page and never exceed MAX_BURST beats.
- Forwards returned read data to the pixel FIFO write port and signals line completion or error.

Parameters:
ADDR_W, 27, AXI byte address width
DATA_W, 128, AXI read data width (16-byte beats)
MAX_BURST, 256, maximum beats per AR burst (power of 2, ≤256)
AXI_ID, 0, constant value driven on mem_arid

Ports:
mem_clk  in  1  memory clock
mem_reset  in  1  asynchronous reset, active-low
req_valid  in  1  line request valid
req_ready  out  1  high only in IDLE
req_addr  in  ADDR_W  line start byte address; bits [3:0] ignored (treated as 0)
req_words  in  10  beats in line, 0..512
mem_arid  out  4  = AXI_ID
mem_araddr  out  ADDR_W  burst address
mem_arlen  out  8  beats-1
mem_arsize  out  3  constant 3'b100
mem_arburst  out  2  constant 2'b01 (INCR)
mem_arlock  out  1  constant 0
mem_arvalid  out  1  address valid
mem_arready  in  1  address accepted
mem_rvalid  in  1  read beat valid
mem_rdata  in  DATA_W  read data
mem_rresp  in  2  read response
mem_rlast  in  1  last beat of burst
mem_rready  out  1  = ~fifo_full
fifo_wr_en  out  1  = mem_rvalid & mem_rready
fifo_din  out  DATA_W  = mem_rdata
fifo_full  in  1  pixel FIFO full
line_done  out  1  one-cycle pulse when all beats of the line have returned
line_err  out  1  sticky; set on any rresp≠0 in the current line, cleared on request accept

Behaviour:
- Reset (mem_reset low, asynchronous):
  - state=IDLE; mem_arvalid=0, mem_araddr=0, mem_arlen=0.
  - line_done=0, line_err=0; beat and remaining counters=0.
  - Constant outputs hold their constant values throughout reset.
- Reset mid-line: the burst is abandoned immediately and arvalid drops. Any beats already in flight are not tracked after reset.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - req_ready=1.
  - On req_valid: latch cur_addr={req_addr[ADDR_W-1:4],4'b0}, remaining=req_words, expected=req_words; clear beats_rcvd and line_err.
  - If req_words=0: line_done pulses on the next cycle, no AR is issued, stay in IDLE.
  - Otherwise go to ISSUE.
- ISSUE, registered burst computation:
  - page_beats=(4096-cur_addr[11:0])>>4, range 1..256.
  - len=min(remaining, page_beats, MAX_BURST).
  - mem_araddr=cur_addr, mem_arlen=len-1, mem_arvalid=1.
  - Computation lands one cycle after entry into ISSUE or after the previous handshake.
- AR handshake rules:
  - araddr and arlen stay stable while arvalid=1 and arready=0.
  - On arvalid&arready: cur_addr+=len*16, remaining-=len, arvalid=0 for at least one cycle.
  - If remaining then becomes 0, go to DRAIN; otherwise recompute and reassert.
- Beat counting (all states after acceptance):
  - beats_rcvd increments on each fifo_wr_en.
  - rresp≠0 on any accepted beat sets line_err.
  - rlast is informational only; it does not drive the counter.
- DRAIN: when beats_rcvd==expected (including a beat arriving this cycle), pulse line_done for one cycle and go to IDLE.
- Beats arriving in IDLE are forwarded to the FIFO but not counted.
- Simultaneous events: a beat in the same cycle as the AR handshake is counted normally. A line's final beat arriving while still in ISSUE is impossible, because the data cannot precede its address.
- Backpressure: mem_rready follows fifo_full combinationally, with no data buffering in the block.
- Widths: remaining and beats_rcvd are 10 bits; address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Package vga_pkg holds:
  - AXI_SIZE_16B=3'b100, AXI_BURST_INCR=2'b01, PAGE_BYTES=4096.
  - Typedef fetch_cs_t {IDLE, ISSUE, DRAIN}.
  - Function burst_len(addr_lo[11:0], remaining, max).
- No sub-module; the burst calculation is the package function.

Test Plan:
- req_addr=0x100, words=40, arready=1 → one AR: addr 0x100, arlen 39; 40 beats; line_done one cycle after the 40th beat; line_err=0.
- req_addr=0xF80, words=40 → AR1 addr 0xF80 arlen 7; AR2 addr 0x1000 arlen 31; line_done after 40 beats.
- req_addr=0, words=512 → AR addr 0 arlen 255, then addr 0x1000 arlen 255; 512 beats counted.
- arready low for 5 cycles → arvalid, araddr and arlen stable for all 5 cycles; single handshake.
- fifo_full=1 for 3 cycles mid-burst → rready=0 and fifo_wr_en=0 in those cycles; beat count unaffected.
- rresp=2 on beat 7 → line_err=1 through line_done; cleared on the next accept. Separately, words=0 → line_done the cycle after accept, no arvalid.
